wb_arbiter_n: RTL and testbench

WB_ARBITER_N -- requirements
Module: wb_arbiter_n

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_arb_pick.sv | 32 +++
 rtl/wb_arbiter_n.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter_n.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types, default parameters and one-hot/index helpers for the Wishbone arbiter family.
package wb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_NUM_MASTERS    = 2;
    localparam int unsigned DEF_RR_MODE        = 0;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned MAX_MASTERS        = 8;
    localparam int unsigned MAX_IDX_W          = 3;

    function automatic logic [MAX_MASTERS-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_MASTERS'(1) << idx;
    endfunction

    // OR-reduction form; the input is expected to be one-hot or zero.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_MASTERS); i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection: fixed (lowest index first) or round-robin from a start pointer.
module wb_arb_pick
    import wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned RR_MODE     = DEF_RR_MODE,
    localparam int unsigned IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic                   o_valid,
    output logic [IDX_W-1:0]       o_idx
);

    int unsigned            w_start;
    logic [NUM_MASTERS-1:0] w_gnt;

    // Walk the requests from the start point with wrap-around; the first hit wins.
    always_comb begin
        w_start = (RR_MODE != 0) ? 32'(i_rr_ptr) : 32'd0;
        w_gnt   = '0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            if ((w_gnt == '0) && i_req[(w_start + 32'(k)) % NUM_MASTERS]) begin
                w_gnt[(w_start + 32'(k)) % NUM_MASTERS] = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = IDX_W'(onehot_to_idx(MAX_MASTERS'(w_gnt)));

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to single-slave Wishbone arbiter with zero-latency grant in IDLE and a bus watchdog.
module wb_arbiter_n
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int unsigned RR_MODE        = DEF_RR_MODE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic                              s_we_o,
    output logic                              s_stb_o,
    output logic                              s_cyc_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_MASTERS);
    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e        r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [WDOG_W-1:0] r_wdog;

    logic              w_pick_valid;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_sel_valid;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_expired;
    logic              w_wd_err;
    logic              w_slv_resp;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    wb_arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .RR_MODE     (RR_MODE)
    ) u_pick (
        .i_req    (m_cyc_i),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_slv_resp = s_ack_i | s_err_i | s_rty_i;
    assign w_expired  = (TIMEOUT_CYCLES != 0) && (r_state == ST_BUSY)
                        && (r_wdog >= WDOG_W'(TIMEOUT_CYCLES));
    // A coincident slave ack or retry wins over the watchdog error.
    assign w_wd_err   = w_expired & ~s_ack_i & ~s_rty_i;

    // Current bus owner: the fresh winner in IDLE, the latched owner while it holds cyc in BUSY.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = r_owner;
        if (!rst_i) begin
            if (r_state == ST_IDLE) begin
                w_sel_valid = w_pick_valid;
                w_sel_idx   = w_pick_idx;
            end else begin
                w_sel_valid = m_cyc_i[r_owner];
            end
        end
    end

    // Route the owner's request to the slave and the slave's response back to the owner only.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        grant_o = '0;
        if (w_sel_valid) begin
            grant_o = NUM_MASTERS'(idx_to_onehot(MAX_IDX_W'(w_sel_idx)));
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (w_sel_valid && (w_sel_idx == IDX_W'(i))) begin
                s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                s_we_o  = m_we_i[i];
                s_stb_o = m_stb_i[i] & ~w_expired;
                s_cyc_o = m_cyc_i[i] & ~w_expired;
                m_dat_o[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
                m_ack_o[i] = s_ack_i;
                m_err_o[i] = s_err_i | w_wd_err;
                m_rty_o[i] = s_rty_i;
            end
        end
    end

    // Ownership FSM, round-robin pointer and saturating watchdog.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (w_pick_valid) begin
                        if (w_slv_resp) begin
                            r_rr_ptr <= next_idx(w_pick_idx);
                        end else begin
                            r_owner <= w_pick_idx;
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i[r_owner] || w_slv_resp || w_expired) begin
                        r_state  <= ST_IDLE;
                        r_wdog   <= '0;
                        r_rr_ptr <= next_idx(r_owner);
                    end else if (s_stb_o && (r_wdog != WDOG_W'(TIMEOUT_CYCLES))) begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: fixed-priority and round-robin instances against a cycle-level reference model.
module tb_wb_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [N*SW-1:0] m_sel = '0;
    logic [N-1:0]    m_we  = '0;
    logic [N-1:0]    m_stb = '0;
    logic [N-1:0]    m_cyc = '0;
    logic [DW-1:0]   s_dat_in = '0;
    logic            s_ack = 1'b0;
    logic            s_err = 1'b0;
    logic            s_rty = 1'b0;

    logic [N*DW-1:0] o_m_dat [2];
    logic [N-1:0]    o_m_ack [2];
    logic [N-1:0]    o_m_err [2];
    logic [N-1:0]    o_m_rty [2];
    logic [N-1:0]    o_grant [2];
    logic [AW-1:0]   o_s_adr [2];
    logic [DW-1:0]   o_s_dat [2];
    logic [SW-1:0]   o_s_sel [2];
    logic            o_s_we  [2];
    logic            o_s_stb [2];
    logic            o_s_cyc [2];

    // Instance 0 is fixed priority, instance 1 round-robin; both see identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_arbiter_n #(
            .ADDR_WIDTH     (AW),
            .DATA_WIDTH     (DW),
            .NUM_MASTERS    (N),
            .RR_MODE        (g),
            .TIMEOUT_CYCLES (T)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .m_adr_i (m_adr),
            .m_dat_i (m_dat),
            .m_sel_i (m_sel),
            .m_we_i  (m_we),
            .m_stb_i (m_stb),
            .m_cyc_i (m_cyc),
            .m_dat_o (o_m_dat[g]),
            .m_ack_o (o_m_ack[g]),
            .m_err_o (o_m_err[g]),
            .m_rty_o (o_m_rty[g]),
            .s_adr_o (o_s_adr[g]),
            .s_dat_o (o_s_dat[g]),
            .s_sel_o (o_s_sel[g]),
            .s_we_o  (o_s_we[g]),
            .s_stb_o (o_s_stb[g]),
            .s_cyc_o (o_s_cyc[g]),
            .s_dat_i (s_dat_in),
            .s_ack_i (s_ack),
            .s_err_i (s_err),
            .s_rty_i (s_rty),
            .grant_o (o_grant[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: who holds the bus, where round-robin resumes, stalled-cycle count.
    int busy  [2];
    int owner [2];
    int ptr   [2];
    int wd    [2];
    int exp_idx [2];
    bit exp_expired [2];
    bit exp_stb [2];

    function automatic int pick(input int k);
        int start;
        start = (k == 1) ? ptr[k] : 0;
        for (int j = 0; j < N; j++) begin
            if (m_cyc[(start + j) % N]) return (start + j) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            string           nm;
            int              idx;
            bit              expired;
            logic [AW-1:0]   e_adr;
            logic [DW-1:0]   e_dat;
            logic [SW-1:0]   e_sel;
            logic [2:0]      e_ctl;
            logic [N-1:0]    e_grant, e_ack, e_err, e_rty;
            logic [N*DW-1:0] e_mdat;
            nm = (k == 1) ? "rr" : "fix";
            idx = -1;
            if (!rst) begin
                if (busy[k] == 0) idx = pick(k);
                else if (m_cyc[owner[k]]) idx = owner[k];
            end
            expired = !rst && (busy[k] != 0) && (wd[k] >= T);
            e_adr = '0; e_dat = '0; e_sel = '0; e_ctl = '0;
            e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_mdat = '0;
            if (idx >= 0) begin
                e_adr = m_adr[idx*AW +: AW];
                e_dat = m_dat[idx*DW +: DW];
                e_sel = m_sel[idx*SW +: SW];
                e_ctl = {m_we[idx], m_stb[idx] && !expired, !expired};
                e_grant[idx] = 1'b1;
                e_mdat[idx*DW +: DW] = s_dat_in;
                e_ack[idx] = s_ack;
                e_rty[idx] = s_rty;
                e_err[idx] = s_err || (expired && !s_ack && !s_rty);
            end
            exp_idx[k]     = idx;
            exp_expired[k] = expired;
            exp_stb[k]     = e_ctl[1];
            check_eq({nm, " s_adr"}, o_s_adr[k], e_adr);
            check_eq({nm, " s_dat"}, o_s_dat[k], e_dat);
            check_eq({nm, " s_sel"}, o_s_sel[k], e_sel);
            check_eq({nm, " s_we/stb/cyc"}, {o_s_we[k], o_s_stb[k], o_s_cyc[k]}, e_ctl);
            check_eq({nm, " grant"}, o_grant[k], e_grant);
            check_eq({nm, " m_dat"}, o_m_dat[k], e_mdat);
            check_eq({nm, " ack/err/rty"}, {o_m_ack[k], o_m_err[k], o_m_rty[k]}, {e_ack, e_err, e_rty});
        end
    endtask

    task automatic model_step();
        bit resp;
        resp = s_ack || s_err || s_rty;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 0; owner[k] = 0; ptr[k] = 0; wd[k] = 0;
            end else if (busy[k] == 0) begin
                wd[k] = 0;
                if (exp_idx[k] >= 0) begin
                    if (resp) ptr[k] = (exp_idx[k] + 1) % N;
                    else begin busy[k] = 1; owner[k] = exp_idx[k]; end
                end
            end else if (!m_cyc[owner[k]] || resp || exp_expired[k]) begin
                busy[k] = 0; wd[k] = 0; ptr[k] = (owner[k] + 1) % N;
            end else if (exp_stb[k] && wd[k] < T) begin
                wd[k]++;
            end
        end
    endtask

    task automatic sample();
        #1 check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_fields();
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW] = $urandom();
            m_dat[i*DW +: DW] = $urandom();
            m_sel[i*SW +: SW] = SW'($urandom());
            m_we[i] = 1'($urandom_range(0, 1));
        end
        s_dat_in = $urandom();
    endtask

    task automatic do_reset();
        rst = 1'b1; m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        drive_fields();
        sample();
        advance();
        rst = 1'b0;
    endtask

    task automatic drive_random(input int phase);
        drive_fields();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, (phase == 1) ? 31 : 7) == 0) m_cyc[i] = ~m_cyc[i];
            m_stb[i] = m_cyc[i] && ((phase == 1) || ($urandom_range(0, 3) != 0));
        end
        case (phase)
            0: begin
                s_ack = ($urandom_range(0, 2) == 0);
                s_err = ($urandom_range(0, 9) == 0);
                s_rty = ($urandom_range(0, 9) == 0);
            end
            1: begin s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; end
            default: begin
                s_ack = ($urandom_range(0, 11) == 0);
                s_err = 1'b0; s_rty = 1'b0;
            end
        endcase
        if (rst) rst = 1'b0;
        else if (phase == 0 && $urandom_range(0, 59) == 0) rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr_order [5];
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; owner[k] = 0; ptr[k] = 0; wd[k] = 0;
        end
        @(negedge clk);
        do_reset();

        // Round-robin with all four requesting, ack one cycle after each grant.
        m_cyc = '1; m_stb = '1;
        for (int c = 0; c < 10; c++) begin
            drive_fields();
            s_ack = (c % 2 == 1);
            sample();
            if (c % 2 == 0) begin
                check_eq("rr order grant", o_grant[1], rr_order[c/2]);
                check_eq("fix order grant", o_grant[0], 4'b0001);
            end
            advance();
        end

        // Silent slave: watchdog error after eight stalled cycles, then re-grant.
        do_reset();
        m_cyc = 4'b0100; m_stb = 4'b0100;
        for (int c = 0; c < 11; c++) begin
            drive_fields();
            sample();
            check_eq("wdog err", o_m_err[1], (c == 9) ? 4'b0100 : 4'b0000);
            check_eq("wdog cyc", o_s_cyc[1], (c != 9));
            check_eq("wdog grant", o_grant[0], 4'b0100);
            advance();
        end

        // Owner drops cyc while master 1 waits; a stray ack must not reach the old owner.
        do_reset();
        m_cyc = 4'b0011; m_stb = 4'b0011;
        drive_fields(); sample(); advance();
        m_cyc = 4'b0010; m_stb = 4'b0010; s_ack = 1'b1;
        drive_fields(); sample();
        check_eq("drop ack", o_m_ack[0], 4'b0000);
        advance();
        s_ack = 1'b0;
        drive_fields(); sample();
        check_eq("drop regrant", o_grant[0], 4'b0010);
        advance();

        // Reset mid-write, then a four-way tie must go to master 0.
        do_reset();
        m_cyc = '1; m_stb = '1;
        for (int c = 0; c < 3; c++) begin
            drive_fields(); m_we = '1; sample(); advance();
        end
        rst = 1'b1;
        sample();
        check_eq("rst s_cyc", {o_s_cyc[1], o_s_cyc[0]}, 2'b00);
        advance();
        rst = 1'b0;
        drive_fields(); sample();
        check_eq("rst tie rr", o_grant[1], 4'b0001);
        check_eq("rst tie fix", o_grant[0], 4'b0001);
        advance();

        // Randomised traffic: mixed responses with resets, silent slave, rare acks.
        for (int phase = 0; phase < 3; phase++) begin
            for (int c = 0; c < 600; c++) begin
                drive_random(phase);
                sample();
                advance();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
